// File: rtl/multi_stream_prefetcher.sv
// Region-tagged multi-stream stride prefetcher between the cache miss path and the DMA miss handler.
// Each stream trains a stride/confidence pair and runs ahead one line at a time through a one-line buffer.
module multi_stream_prefetcher #(
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 32,
  parameter int num_streams_p = 4,
  parameter int region_bits_p = 12,
  parameter int conf_thresh_p = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    miss_v_i,
  input  logic [addr_width_p-1:0] miss_addr_i,
  output logic                    prefetch_dma_v_o,
  output logic [addr_width_p-1:0] prefetch_dma_addr_o,
  input  logic                    prefetch_dma_ready_i,
  input  logic                    dma_prefetch_data_v_i,
  input  logic [data_width_p-1:0] dma_prefetch_data_i,
  input  logic                    cache_pkt_v_i,
  input  logic [addr_width_p-1:0] cache_pkt_addr_i,
  output logic                    prefetch_data_v_o,
  output logic [data_width_p-1:0] prefetch_data_o
);

  localparam int idx_w_lp = $clog2(num_streams_p);
  localparam int tag_w_lp = addr_width_p - region_bits_p;
  localparam logic [1:0] conf_thresh_lp = 2'(conf_thresh_p);

  typedef enum logic [1:0] {EMPTY, REQ, WAIT, FULL} pf_state_e;
  typedef logic [addr_width_p-1:0] addr_t;

  logic [num_streams_p-1:0] valid_r;
  logic [tag_w_lp-1:0]      tag_r       [num_streams_p];
  addr_t                    last_addr_r [num_streams_p];
  addr_t                    stride_r    [num_streams_p];
  logic [1:0]               conf_r      [num_streams_p];
  addr_t                    pf_addr_r   [num_streams_p];
  logic [data_width_p-1:0]  pf_data_r   [num_streams_p];
  pf_state_e                pf_state_r  [num_streams_p];

  logic                outstanding_r;
  logic                drop_r;
  logic [idx_w_lp-1:0] out_id_r;
  logic [idx_w_lp-1:0] vptr_r;

  logic [tag_w_lp-1:0] miss_tag;
  logic                miss_hit, free_found, req_found, cons_found;
  logic [idx_w_lp-1:0] miss_idx, free_idx, req_idx, cons_idx, alloc_idx;

  assign miss_tag = miss_addr_i[addr_width_p-1:region_bits_p];

  // Priority searches scan downward so the lowest matching index wins.
  always_comb begin
    miss_hit   = 1'b0;
    miss_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    req_found  = 1'b0;
    req_idx    = '0;
    cons_found = 1'b0;
    cons_idx   = '0;
    for (int i = num_streams_p - 1; i >= 0; i--) begin
      if (valid_r[i] && (tag_r[i] == miss_tag)) begin
        miss_hit = 1'b1;
        miss_idx = idx_w_lp'(i);
      end
      if (!valid_r[i]) begin
        free_found = 1'b1;
        free_idx   = idx_w_lp'(i);
      end
      if (pf_state_r[i] == REQ) begin
        req_found = 1'b1;
        req_idx   = idx_w_lp'(i);
      end
      if (valid_r[i] && (pf_state_r[i] == FULL) && (pf_addr_r[i] == cache_pkt_addr_i)) begin
        cons_found = 1'b1;
        cons_idx   = idx_w_lp'(i);
      end
    end
  end

  logic cons_v, fire, ret;

  assign prefetch_dma_v_o    = reset_n_i && !outstanding_r && req_found;
  assign prefetch_dma_addr_o = prefetch_dma_v_o ? pf_addr_r[req_idx] : '0;
  assign cons_v              = reset_n_i && cache_pkt_v_i && cons_found;
  assign prefetch_data_v_o   = cons_v;
  assign prefetch_data_o     = cons_v ? pf_data_r[cons_idx] : '0;

  assign fire = prefetch_dma_v_o && prefetch_dma_ready_i;
  assign ret  = dma_prefetch_data_v_i && outstanding_r;

  addr_t      new_stride, stride_delta;
  logic [1:0] conf_cur, new_conf;
  logic       stride_ok, trig, alloc, alloc_wait;

  // An entry that fires this cycle counts as WAIT for a colliding miss, so the
  // in-flight address is never rewritten and a reallocation still drops its data.
  always_comb begin
    stride_delta = miss_addr_i - last_addr_r[miss_idx];
    conf_cur     = conf_r[miss_idx];
    stride_ok    = (stride_delta == stride_r[miss_idx]) && (stride_delta != '0);
    new_stride   = stride_ok ? stride_r[miss_idx] : stride_delta;
    new_conf     = '0;
    if (stride_ok) begin
      new_conf = (conf_cur == 2'd3) ? 2'd3 : conf_cur + 2'd1;
    end
    trig = miss_v_i && miss_hit && (new_conf >= conf_thresh_lp) &&
           (pf_state_r[miss_idx] != WAIT) && !(fire && (req_idx == miss_idx));
    alloc      = miss_v_i && !miss_hit;
    alloc_idx  = free_found ? free_idx : vptr_r;
    alloc_wait = ((pf_state_r[alloc_idx] == WAIT) && !(ret && (out_id_r == alloc_idx))) ||
                 (fire && (req_idx == alloc_idx));
  end

  // Later assignments override earlier ones: consume, return, issue, then miss.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      valid_r       <= '0;
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
      out_id_r      <= '0;
      vptr_r        <= '0;
      for (int i = 0; i < num_streams_p; i++) begin
        pf_state_r[i] <= EMPTY;
      end
    end else begin
      if (cons_v) begin
        last_addr_r[cons_idx] <= pf_addr_r[cons_idx];
        if (conf_r[cons_idx] >= conf_thresh_lp) begin
          pf_state_r[cons_idx] <= REQ;
          pf_addr_r[cons_idx]  <= pf_addr_r[cons_idx] + stride_r[cons_idx];
        end else begin
          pf_state_r[cons_idx] <= EMPTY;
        end
      end

      if (ret) begin
        outstanding_r <= 1'b0;
        drop_r        <= 1'b0;
        if (!drop_r) begin
          pf_data_r[out_id_r]  <= dma_prefetch_data_i;
          pf_state_r[out_id_r] <= FULL;
        end
      end

      if (fire) begin
        pf_state_r[req_idx] <= WAIT;
        outstanding_r       <= 1'b1;
        out_id_r            <= req_idx;
      end

      if (miss_v_i && miss_hit) begin
        last_addr_r[miss_idx] <= miss_addr_i;
        stride_r[miss_idx]    <= new_stride;
        conf_r[miss_idx]      <= new_conf;
        if (trig) begin
          pf_state_r[miss_idx] <= REQ;
          pf_addr_r[miss_idx]  <= miss_addr_i + new_stride;
        end
      end

      if (alloc) begin
        valid_r[alloc_idx]     <= 1'b1;
        tag_r[alloc_idx]       <= miss_tag;
        last_addr_r[alloc_idx] <= miss_addr_i;
        stride_r[alloc_idx]    <= '0;
        conf_r[alloc_idx]      <= '0;
        pf_state_r[alloc_idx]  <= EMPTY;
        if (alloc_wait) begin
          drop_r <= 1'b1;
        end
        if (!free_found) begin
          vptr_r <= (vptr_r == idx_w_lp'(num_streams_p - 1)) ? '0 : vptr_r + idx_w_lp'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_stream_prefetcher.sv
// Self-checking bench for multi_stream_prefetcher: directed scenarios with literal
// expectations plus a randomized phase compared every cycle against a behavioural stream model.
module tb_multi_stream_prefetcher;

  localparam int NS      = 4;
  localparam int THRESH  = 2;
  localparam int S_EMPTY = 0;
  localparam int S_REQ   = 1;
  localparam int S_WAIT  = 2;
  localparam int S_FULL  = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        miss_v = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        dma_v;
  logic [31:0] dma_addr;
  logic        dma_ready = 1'b0;
  logic        dret_v = 1'b0;
  logic [31:0] dret_data = '0;
  logic        cache_v = 1'b0;
  logic [31:0] cache_addr = '0;
  logic        data_v;
  logic [31:0] data_out;

  always #5 clk = ~clk;

  multi_stream_prefetcher dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .miss_v_i              (miss_v),
    .miss_addr_i           (miss_addr),
    .prefetch_dma_v_o      (dma_v),
    .prefetch_dma_addr_o   (dma_addr),
    .prefetch_dma_ready_i  (dma_ready),
    .dma_prefetch_data_v_i (dret_v),
    .dma_prefetch_data_i   (dret_data),
    .cache_pkt_v_i         (cache_v),
    .cache_pkt_addr_i      (cache_addr),
    .prefetch_data_v_o     (data_v),
    .prefetch_data_o       (data_out)
  );

  typedef struct {
    bit        valid;
    bit [19:0] tag;
    bit [31:0] last_addr;
    bit [31:0] stride;
    bit [31:0] pf_addr;
    bit [31:0] pf_data;
    int        conf;
    int        st;
  } stream_t;

  stream_t   mdl [NS];
  bit        mdl_out, mdl_drop;
  int        mdl_out_id, mdl_vptr;
  bit        exp_dma_v, exp_data_v;
  bit [31:0] exp_dma_addr, exp_data;
  int        checks = 0;
  int        errors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: outputs from the current stream table, then the cycle's updates in
  // consume / return / issue / miss order, all reading the start-of-cycle table.
  always @(negedge clk) begin
    int        req, hit, m, t, old_id;
    bit        fire, ret;
    bit [31:0] ns;
    stream_t   pre [NS];

    req = -1;
    hit = -1;
    if (reset_n && !mdl_out)
      for (int i = NS - 1; i >= 0; i--) if (mdl[i].st == S_REQ) req = i;
    if (reset_n && cache_v)
      for (int i = NS - 1; i >= 0; i--)
        if (mdl[i].valid && mdl[i].st == S_FULL && mdl[i].pf_addr == cache_addr) hit = i;
    exp_dma_v = (req >= 0);
    exp_dma_addr = '0;
    if (req >= 0) exp_dma_addr = mdl[req].pf_addr;
    exp_data_v = (hit >= 0);
    exp_data = '0;
    if (hit >= 0) exp_data = mdl[hit].pf_data;

    checkOutput("dma_v", dma_v, exp_dma_v);
    if (exp_dma_v) checkOutput("dma_addr", dma_addr, exp_dma_addr);
    checkOutput("data_v", data_v, exp_data_v);
    checkOutput("data", data_out, exp_data);

    if (!reset_n) begin
      for (int i = 0; i < NS; i++) begin
        mdl[i].valid = 1'b0;
        mdl[i].st = S_EMPTY;
      end
      mdl_out = 1'b0;
      mdl_drop = 1'b0;
      mdl_vptr = 0;
    end else begin
      pre = mdl;
      old_id = mdl_out_id;
      fire = exp_dma_v && dma_ready;
      ret = dret_v && mdl_out;
      if (hit >= 0) begin
        mdl[hit].last_addr = pre[hit].pf_addr;
        if (pre[hit].conf >= THRESH) begin
          mdl[hit].st = S_REQ;
          mdl[hit].pf_addr = pre[hit].pf_addr + pre[hit].stride;
        end else mdl[hit].st = S_EMPTY;
      end
      if (ret) begin
        if (!mdl_drop) begin
          mdl[old_id].pf_data = dret_data;
          mdl[old_id].st = S_FULL;
        end
        mdl_out = 1'b0;
        mdl_drop = 1'b0;
      end
      if (fire) begin
        mdl[req].st = S_WAIT;
        mdl_out = 1'b1;
        mdl_out_id = req;
      end
      if (miss_v) begin
        m = -1;
        for (int i = NS - 1; i >= 0; i--) if (pre[i].valid && pre[i].tag == miss_addr[31:12]) m = i;
        if (m >= 0) begin
          ns = miss_addr - pre[m].last_addr;
          if (ns == pre[m].stride && ns != 0) mdl[m].conf = (pre[m].conf == 3) ? 3 : pre[m].conf + 1;
          else begin
            mdl[m].stride = ns;
            mdl[m].conf = 0;
          end
          mdl[m].last_addr = miss_addr;
          if (mdl[m].conf >= THRESH && pre[m].st != S_WAIT && !(fire && req == m)) begin
            mdl[m].st = S_REQ;
            mdl[m].pf_addr = miss_addr + mdl[m].stride;
          end
        end else begin
          t = -1;
          for (int i = NS - 1; i >= 0; i--) if (!pre[i].valid) t = i;
          if (t < 0) begin
            t = mdl_vptr;
            mdl_vptr = (mdl_vptr + 1) % NS;
          end
          if ((pre[t].st == S_WAIT && !(ret && old_id == t)) || (fire && req == t)) mdl_drop = 1'b1;
          mdl[t].valid = 1'b1;
          mdl[t].tag = miss_addr[31:12];
          mdl[t].last_addr = miss_addr;
          mdl[t].stride = '0;
          mdl[t].conf = 0;
          mdl[t].st = S_EMPTY;
        end
      end
    end
  end

  // Sets the inputs for the next clock cycle, just after the rising edge.
  task automatic applyStimulus(input bit mv, input bit [31:0] ma, input bit rdy,
                               input bit rv, input bit [31:0] rd, input bit cv, input bit [31:0] ca);
    @(posedge clk);
    #1;
    miss_v = mv;
    miss_addr = ma;
    dma_ready = rdy;
    dret_v = rv;
    dret_data = rd;
    cache_v = cv;
    cache_addr = ca;
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, '0, rdy, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    miss_v = 1'b0;
    dma_ready = 1'b0;
    dret_v = 1'b0;
    cache_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  task automatic trainUnitStream(input bit rdy);
    applyStimulus(1'b1, 32'h1000, rdy, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h1040, rdy, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h1080, rdy, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h10C0, rdy, 1'b0, '0, 1'b0, '0);
  endtask

  bit [31:0] stride_tab [5];
  bit [31:0] rbase [6];
  bit [31:0] rstride [6];
  bit [31:0] rcnt [6];

  initial begin
    int r, k;
    stride_tab = '{32'h10, 32'h20, 32'h40, 32'hFFFF_FFE0, 32'h0};

    // Reset state and the first cycle after it.
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    sampleNow();
    checkOutput("reset_dma_v", dma_v, 1'b0);
    checkOutput("reset_data_v", data_v, 1'b0);

    // Stride training, return, consume and run-ahead with backpressure.
    trainUnitStream(1'b1);
    sampleNow();
    checkOutput("train_no_early_v", dma_v, 1'b0);
    idle(1'b1);
    sampleNow();
    checkOutput("train_v", dma_v, 1'b1);
    checkOutput("train_addr", dma_addr, 32'h1100);
    checkOutput("model_train_addr", exp_dma_addr, 32'h1100);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, '0);
    sampleNow();
    checkOutput("outstanding_v", dma_v, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 32'h1100);
    sampleNow();
    checkOutput("hit_v", data_v, 1'b1);
    checkOutput("hit_data", data_out, 32'hDEADBEEF);
    checkOutput("model_hit_data", exp_data, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      idle(1'b0);
      sampleNow();
      checkOutput("bp_v", dma_v, 1'b1);
      checkOutput("bp_addr", dma_addr, 32'h1140);
    end
    idle(1'b1);
    sampleNow();
    checkOutput("bp_fire_v", dma_v, 1'b1);
    checkOutput("model_runahead_addr", exp_dma_addr, 32'h1140);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, '0);
    sampleNow();
    checkOutput("bp_after_fire_v", dma_v, 1'b0);

    // Interleaved streams, one upward in region 0x2, one downward crossing 0x9 into 0x8.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h2000 + 32'(i) * 32'h20, 1'b0, 1'b0, '0, 1'b0, '0);
      applyStimulus(1'b1, 32'h9000 - 32'(i) * 32'h10, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    applyStimulus(1'b1, 32'h8FC0, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(1'b1);
    sampleNow();
    checkOutput("ilv_first_addr", dma_addr, 32'h2080);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'hAAAA0001, 1'b0, '0);
    sampleNow();
    checkOutput("ilv_serial_v", dma_v, 1'b0);
    idle(1'b1);
    sampleNow();
    checkOutput("ilv_second_v", dma_v, 1'b1);
    checkOutput("ilv_second_addr", dma_addr, 32'h8FB0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hBBBB0002, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 32'h2080);
    sampleNow();
    checkOutput("ilv_hit_data", data_out, 32'hAAAA0001);

    // Reallocating a WAIT entry discards its returning data.
    doReset();
    trainUnitStream(1'b0);
    applyStimulus(1'b1, 32'h4000, 1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h5000, 1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b1, 32'h6000, 1'b0, 1'b0, '0, 1'b0, '0);
    idle(1'b1);
    sampleNow();
    checkOutput("drop_fire_addr", dma_addr, 32'h1100);
    applyStimulus(1'b1, 32'h7000, 1'b1, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h12345678, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 32'h1100);
    sampleNow();
    checkOutput("drop_hit_v", data_v, 1'b0);
    checkOutput("drop_data", data_out, 32'h0);

    // Reset while a prefetch is in flight; the late return must be ignored.
    doReset();
    trainUnitStream(1'b1);
    idle(1'b1);
    idle(1'b0);
    reset_n = 1'b0;
    sampleNow();
    checkOutput("midreset_v", dma_v, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h55AA55AA, 1'b1, 32'h1100);
    reset_n = 1'b1;
    sampleNow();
    checkOutput("midreset_first_v", dma_v, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 32'h1100);
    sampleNow();
    checkOutput("midreset_hit_v", data_v, 1'b0);

    // Zero stride never gains confidence.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h3000, 1'b1, 1'b0, '0, 1'b0, '0);
    idle(1'b1);
    sampleNow();
    checkOutput("zero_stride_v", dma_v, 1'b0);
    idle(1'b1);
    sampleNow();
    checkOutput("zero_stride_v2", dma_v, 1'b0);

    // Randomized traffic over six regions with assorted strides.
    for (int i = 0; i < 6; i++) begin
      rbase[i] = (32'(i) + 32'd1) * 32'h10000 + 32'h800;
      rstride[i] = stride_tab[i % 5];
      rcnt[i] = '0;
    end
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset_n = ($urandom_range(0, 399) != 0);
      miss_v = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 5);
      if ($urandom_range(0, 15) == 0) miss_addr = $urandom;
      else begin
        miss_addr = rbase[r] + rcnt[r] * rstride[r];
        if (miss_v) rcnt[r]++;
        if (rcnt[r] > 24) begin
          rcnt[r] = '0;
          rstride[r] = stride_tab[$urandom_range(0, 4)];
        end
      end
      dma_ready = ($urandom_range(0, 9) < 7);
      dret_v = ($urandom_range(0, 9) < 4);
      dret_data = $urandom;
      cache_v = ($urandom_range(0, 9) < 5);
      k = $urandom_range(0, NS - 1);
      if ($urandom_range(0, 3) != 0) cache_addr = mdl[k].pf_addr;
      else cache_addr = rbase[r] + rcnt[r] * rstride[r];
    end
    reset_n = 1'b1;
    repeat (4) idle(1'b1);
    sampleNow();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
